bubble_sort_ctrl: RTL and testbench
===================================

# bubble_sort_ctrl

Sequencing master that drives the 32-entry register file's access port: on `start` it bubble-sorts entries `0..DEPTH-1` in place, ascending and unsigned, by issuing read and write transactions on the register file interface. It is the initiator side of the register file protocol. It sits between the top-level control (start/busy/done) and the register file, and owns the file's address, mode, write-enable and write-data inputs while `busy`.

## Interface
- `DEPTH`, default 32: number of entries sorted, starting at address 0. Legal range 2..32.
- `DATA_W`, default 32: word width.
- `ADDR_W`, default 5: register file address width.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `start` input 1: level sampled each cycle in IDLE; starts a sort.
- `busy` output 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` output 1: one-cycle pulse when the sort completes.
- `swaps` output 16: count of swaps in the last or current sort; saturates at 16'hFFFF.
- `rf_addr` output ADDR_W: register file address.
- `rf_mode` output 1: 0 = read, 1 = write.
- `rf_we` output 1: write enable; high only in WR_A and WR_B.
- `rf_wdata` output DATA_W: write data.
- `rf_rdata` input DATA_W: register file read data, valid in the cycle after `rf_addr` is sampled (1-cycle read latency).

## Operation
- States: IDLE, RD_A, RD_B, CMP, WR_A, WR_B, DONE.
- Internal registers:
  - `idx` (ADDR_W): current compare position.
  - `limit` (ADDR_W+1): entries in the current pass.
  - `swapped` (1): any swap in the current pass.
  - `a_q`, `b_q` (DATA_W): operand latches.
- IDLE: if `start`, go to RD_A; load `idx`=0, `limit`=DEPTH, `swapped`=0, `swaps`=0.
- RD_A: drive `rf_addr`=`idx`, `rf_mode`=0; go to RD_B.
- RD_B: drive `rf_addr`=`idx+1`, `rf_mode`=0; latch `a_q`=`rf_rdata`; go to CMP.
- CMP: latch `b_q`=`rf_rdata`.
  - If `rf_rdata` < `a_q` (unsigned): go to WR_A.
  - Otherwise advance.
- WR_A: drive `rf_addr`=`idx`, `rf_mode`=1, `rf_we`=1, `rf_wdata`=`b_q`; go to WR_B.
- WR_B: drive `rf_addr`=`idx+1`, `rf_mode`=1, `rf_we`=1, `rf_wdata`=`a_q`; set `swapped`, increment `swaps` (saturating); advance.
- Advance: if `idx+2` < `limit`, then `idx`++ and go to RD_A. Otherwise the pass has ended:
  - If `swapped`=0 or `limit`=2: go to DONE.
  - Else: `limit`--, `idx`=0, `swapped`=0, go to RD_A.
- DONE: `done`=1, `busy`=1; go to IDLE.
- `start` while busy: ignored; no queueing.
- Equal values are never swapped, so the sort is stable.
- Idle bus values: `rf_addr`=0, `rf_mode`=0, `rf_we`=0, `rf_wdata`=0 in IDLE and DONE.

## Timing
- Reset values: state IDLE; `busy`, `done`, `rf_we`, `rf_mode` = 0; `rf_addr`, `rf_wdata`, `swaps` = 0; internal registers cleared.
- Reset asserted mid-sort: immediate abort to IDLE with all outputs at reset values. Register file contents are left partially sorted; a write in flight at assertion is not guaranteed.
- Compare cost: 3 cycles without a swap (RD_A, RD_B, CMP); 5 cycles with a swap (+WR_A, WR_B).
- Write-then-read hazard: WR_B writes `idx+1`, then the next RD_A reads that address. The write commits at the same edge that registers the new address, so the read returns the written value and no bubble is needed.
- Start-to-done latency, `start` accepted at edge T, already-sorted input: DONE occupies cycle T+1+3·(DEPTH−1).
- Worst case (reverse-sorted input): DEPTH·(DEPTH−1)/2 compares, all swapping, at 5 cycles each, plus 1 DONE cycle.
- Outputs: all registered and glitch-free, except that `rf_*` are decoded from the state register plus registered `idx`/`a_q`/`b_q`.

## Structure
- Shared package `bubble_pkg`:
  - State enum `sort_state_t`.
  - Constants `RF_READ`=1'b0 and `RF_WRITE`=1'b1.
  - `RF_DEPTH`=32 and `RF_ADDR_W`=5, shared with the register file.
- Single module; no sub-module. The comparator and counters stay inline.

## Test plan
- Sorted input, DEPTH=4, file = {1,2,3,4}; pulse `start` -> no `rf_we` ever; `done` exactly 10 cycles after the acceptance edge; `swaps`=0.
- Reverse input, DEPTH=4, file = {4,3,2,1} -> final file {1,2,3,4}; `swaps`=6; `done` at cycle 31 after acceptance.
- Duplicates, DEPTH=5, file = {3,1,3,0,1} -> final {0,1,1,3,3}; `swaps`=6; no write is issued for any equal pair.
- Unsigned extremes, DEPTH=2, file = {32'hFFFF_FFFF, 0} -> final {0, 32'hFFFF_FFFF}; `swaps`=1; exactly 2 write cycles.
- Reset during WR_A of the first swap on {4,3,2,1} -> all outputs 0 in the same cycle; a later `start` completes to {1,2,3,4}.
- `start` held high throughout a sort -> exactly one `done` pulse per sort. After DONE the block re-enters IDLE, accepts the still-high `start` and re-sorts: `swaps`=0, sort-only reads.

Source files
------------

// File: rtl/bubble_pkg.sv
// rtl/bubble_pkg.sv - shared types and constants for the bubble sort controller and register file
package bubble_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_CMP,
    S_WR_A,
    S_WR_B,
    S_DONE
  } sort_state_t;

  localparam logic RF_READ   = 1'b0;
  localparam logic RF_WRITE  = 1'b1;
  localparam int   RF_DEPTH  = 32;
  localparam int   RF_ADDR_W = 5;

endpackage

// File: rtl/bubble_sort_ctrl.sv
// rtl/bubble_sort_ctrl.sv - in-place ascending bubble sort master on the register file access port
module bubble_sort_ctrl
  import bubble_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int DATA_W = 32,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       swaps,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_mode,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  localparam logic [ADDR_W:0] LIMIT_INIT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LIMIT_MIN  = (ADDR_W+1)'(2);

  sort_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   limit_q, limit_d;
  logic              swapped_q, swapped_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [15:0]       swaps_q, swaps_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] idx_next;
  logic [ADDR_W:0]   idx_plus2;
  logic              advance;
  logic              pass_swapped;

  assign idx_next  = idx_q + ADDR_W'(1);
  assign idx_plus2 = {1'b0, idx_q} + (ADDR_W+1)'(2);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    limit_d      = limit_q;
    swapped_d    = swapped_q;
    a_d          = a_q;
    b_d          = b_q;
    swaps_d      = swaps_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    advance      = 1'b0;
    pass_swapped = swapped_q;
    rf_addr      = '0;
    rf_mode      = RF_READ;
    rf_we        = 1'b0;
    rf_wdata     = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RD_A;
          idx_d     = '0;
          limit_d   = LIMIT_INIT;
          swapped_d = 1'b0;
          swaps_d   = '0;
          busy_d    = 1'b1;
        end
      end
      S_RD_A: begin
        rf_addr = idx_q;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        rf_addr = idx_next;
        a_d     = rf_rdata;
        state_d = S_CMP;
      end
      S_CMP: begin
        b_d = rf_rdata;
        // strict compare keeps equal keys in place, which makes the sort stable
        if (rf_rdata < a_q) state_d = S_WR_A;
        else                advance = 1'b1;
      end
      S_WR_A: begin
        rf_addr  = idx_q;
        rf_mode  = RF_WRITE;
        rf_we    = 1'b1;
        rf_wdata = b_q;
        state_d  = S_WR_B;
      end
      S_WR_B: begin
        rf_addr      = idx_next;
        rf_mode      = RF_WRITE;
        rf_we        = 1'b1;
        rf_wdata     = a_q;
        swapped_d    = 1'b1;
        pass_swapped = 1'b1;
        if (swaps_q != 16'hFFFF) swaps_d = swaps_q + 16'd1;
        advance      = 1'b1;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (idx_plus2 < limit_q) begin
        idx_d   = idx_next;
        state_d = S_RD_A;
      end else if (!pass_swapped || limit_q == LIMIT_MIN) begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        // last slot of this pass now holds its final value; shrink the window
        limit_d   = limit_q - (ADDR_W+1)'(1);
        idx_d     = '0;
        swapped_d = 1'b0;
        state_d   = S_RD_A;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      limit_q   <= '0;
      swapped_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      swaps_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      limit_q   <= limit_d;
      swapped_q <= swapped_d;
      a_q       <= a_d;
      b_q       <= b_d;
      swaps_q   <= swaps_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign swaps = swaps_q;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// tb/tb_bubble_sort_ctrl.sv - self-checking bench for bubble_sort_ctrl at several depths
module tb_bubble_sort_ctrl;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start    [NI];
  logic        busy     [NI];
  logic        done     [NI];
  logic [15:0] swaps    [NI];
  logic [4:0]  rf_addr  [NI];
  logic        rf_mode  [NI];
  logic        rf_we    [NI];
  logic [31:0] rf_wdata [NI];
  logic [31:0] rf_rdata [NI];

  logic [31:0] mem [NI][32];
  logic        ld_en;
  int          ld_k;
  logic [4:0]  ld_a;
  logic [31:0] ld_d;

  logic [31:0] vec   [32];
  logic [31:0] ref_v [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int depth_of(input int k);
    case (k)
      0:       return 2;
      1:       return 4;
      2:       return 5;
      default: return 8;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 5 : 8;
    bubble_sort_ctrl #(.DEPTH(D), .DATA_W(32), .ADDR_W(5)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .swaps    (swaps[g]),
      .rf_addr  (rf_addr[g]),
      .rf_mode  (rf_mode[g]),
      .rf_we    (rf_we[g]),
      .rf_wdata (rf_wdata[g]),
      .rf_rdata (rf_rdata[g])
    );
  end

  // register file model: write commits at the edge, read data registered from the sampled address
  always_ff @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rf_we[g] && rf_mode[g]) mem[g][rf_addr[g]] <= rf_wdata[g];
      else if (ld_en && ld_k == g) mem[g][ld_a] <= ld_d;
      rf_rdata[g] <= mem[g][rf_addr[g]];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_mem(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      ld_en = 1'b1; ld_k = k; ld_a = 5'(i); ld_d = vec[i];
      @(negedge clk);
    end
    ld_en = 1'b0;
  endtask

  // textbook bubble sort with early exit; cost 3 cycles per compare, +2 per swap, +1 DONE
  function automatic void model(input int n, output int sw, output int lat);
    int lim, cmps;
    bit any, go;
    logic [31:0] t;
    for (int i = 0; i < 32; i++) ref_v[i] = vec[i];
    sw = 0; cmps = 0; lim = n; go = 1'b1;
    while (go) begin
      any = 1'b0;
      for (int i = 0; i + 1 < lim; i++) begin
        cmps++;
        if (ref_v[i+1] < ref_v[i]) begin
          t = ref_v[i]; ref_v[i] = ref_v[i+1]; ref_v[i+1] = t;
          sw++; any = 1'b1;
        end
      end
      if (!any || lim == 2) go = 1'b0;
      else lim--;
    end
    lat = 3 * cmps + 2 * sw + 1;
  endfunction

  task automatic run_sort(input int k, input bit hold, output int lat, output int sw_out,
                          output int writes, output int pviol);
    bit prev_we;
    logic [31:0] w1;
    int d;
    d = depth_of(k); prev_we = 1'b0; w1 = '0;
    lat = -1; sw_out = 0; writes = 0; pviol = 0;
    start[k] = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (!hold) start[k] = 1'b0;
      if (!busy[k]) pviol++;
      if (rf_we[k] !== rf_mode[k]) pviol++;
      if (int'(rf_addr[k]) >= d) pviol++;
      if (rf_we[k]) begin
        writes++;
        if (!prev_we) w1 = rf_wdata[k];
        else if (rf_wdata[k] <= w1) pviol++;
      end
      prev_we = rf_we[k];
      if (done[k]) begin
        lat = n; sw_out = int'(swaps[k]);
        break;
      end
    end
    check_eq($sformatf("timeout_k%0d", k), 64'(lat < 0), 64'(0));
    @(negedge clk);
    check_eq($sformatf("done_pulse_k%0d", k), 64'(done[k]), 64'(0));
    check_eq($sformatf("busy_idle_k%0d", k), 64'(busy[k]), 64'(0));
  endtask

  task automatic do_case(input string name, input int k, input bit do_load, input bit hold);
    int d, esw, elat, lat, sw, wr, pv;
    d = depth_of(k);
    if (do_load) load_mem(k, d);
    model(d, esw, elat);
    run_sort(k, hold, lat, sw, wr, pv);
    check_eq({name, "_lat"}, 64'(lat), 64'(elat));
    check_eq({name, "_swaps"}, 64'(sw), 64'(esw));
    check_eq({name, "_writes"}, 64'(wr), 64'(2 * esw));
    check_eq({name, "_proto"}, 64'(pv), 64'(0));
    for (int i = 0; i < d; i++)
      check_eq($sformatf("%s_mem%0d", name, i), 64'(mem[k][i]), 64'(ref_v[i]));
  endtask

  initial begin
    int lat, sw, wr, pv, k;
    rst = 1'b0; ld_en = 1'b0; ld_k = 0; ld_a = '0; ld_d = '0;
    for (int i = 0; i < NI; i++) start[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("reset_k%0d", i),
               64'({busy[i], done[i], swaps[i], rf_addr[i], rf_mode[i], rf_we[i], rf_wdata[i]}), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    vec[0] = 1; vec[1] = 2; vec[2] = 3; vec[3] = 4;
    do_case("sorted4", 1, 1'b1, 1'b0);

    vec[0] = 4; vec[1] = 3; vec[2] = 2; vec[3] = 1;
    do_case("reverse4", 1, 1'b1, 1'b0);

    vec[0] = 3; vec[1] = 1; vec[2] = 3; vec[3] = 0; vec[4] = 1;
    do_case("dups5", 2, 1'b1, 1'b0);

    vec[0] = 32'hFFFF_FFFF; vec[1] = 32'h0;
    do_case("extreme2", 0, 1'b1, 1'b0);

    // abort during WR_A of the first swap
    vec[0] = 4; vec[1] = 3; vec[2] = 2; vec[3] = 1;
    load_mem(1, 4);
    start[1] = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      start[1] = 1'b0;
      if (rf_we[1]) break;
    end
    check_eq("reach_wr_a", 64'(rf_we[1]), 64'(1));
    rst = 1'b0;
    #1;
    check_eq("abort_out", 64'({busy[1], done[1], swaps[1], rf_addr[1], rf_mode[1], rf_we[1], rf_wdata[1]}), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model(4, sw, lat);
    run_sort(1, 1'b0, lat, sw, wr, pv);
    check_eq("abort_proto", 64'(pv), 64'(0));
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("abort_mem%0d", i), 64'(mem[1][i]), 64'(ref_v[i]));

    // start held high: first sort, then an immediate re-sort of already-sorted data
    for (int i = 0; i < 4; i++) vec[i] = $urandom_range(0, 9);
    do_case("hold_a", 1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) vec[i] = ref_v[i];
    do_case("hold_b", 1, 1'b0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      k = (it % 2 == 1) ? 3 : 2;
      for (int i = 0; i < depth_of(k); i++)
        vec[i] = (it < 4) ? 32'($urandom_range(0, 3)) : 32'($urandom());
      do_case($sformatf("rand%0d", it), k, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
